rrf_alloc_ctrl: RTL and testbench

- Allocation controller for the rename register file (RRF).
- Hands out up to two RRF tags per cycle to dispatching instructions that write a destination register, and reclaims tags in order as the commit stage retires them.
- Tracks the free count and raises a dispatch stall when there are too few free tags.
- Restores the allocation pointer on a pipeline flush.
- Sits in the dispatch stage. Its slot-1 and slot-2 tag/enable outputs drive the RRF allocate ports.

---
 rtl/rrf_alloc_ctrl_if.sv | 37 +++
 rtl/rrf_alloc_ctrl.sv | 74 +++++++
 tb/tb_rrf_alloc_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rrf_alloc_ctrl_if.sv
// +----------------------------------------------------------------------+
// | rrf_alloc_ctrl_if : dispatch/commit bundle for the RRF allocator     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface rrf_alloc_ctrl_if #(
  parameter int RRF_SEL = 6
) ();
  logic               req1_i;
  logic               req2_i;
  logic               stall_dp_i;
  logic [1:0]         com_num_i;
  logic               flush_i;
  logic               alloc_en1_o;
  logic [RRF_SEL-1:0] alloc_tag1_o;
  logic               alloc_en2_o;
  logic [RRF_SEL-1:0] alloc_tag2_o;
  logic               alloc_stall_o;
  logic [RRF_SEL:0]   freenum_o;
  logic [RRF_SEL-1:0] rrfptr_o;
  logic [RRF_SEL-1:0] comptr_o;

  modport master (
    output req1_i, req2_i, stall_dp_i, com_num_i, flush_i,
    input  alloc_en1_o, alloc_tag1_o, alloc_en2_o, alloc_tag2_o,
    input  alloc_stall_o, freenum_o, rrfptr_o, comptr_o
  );

  modport slave (
    input  req1_i, req2_i, stall_dp_i, com_num_i, flush_i,
    output alloc_en1_o, alloc_tag1_o, alloc_en2_o, alloc_tag2_o,
    output alloc_stall_o, freenum_o, rrfptr_o, comptr_o
  );
endinterface

`default_nettype wire

// File: rtl/rrf_alloc_ctrl.sv
// +----------------------------------------------------------------------+
// | rrf_alloc_ctrl : two-wide RRF tag allocator with in-order reclaim    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rrf_alloc_ctrl #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6
) (
  input  wire logic         clk_i,
  input  wire logic         reset_i,
  rrf_alloc_ctrl_if.slave   bus
);

  localparam logic [RRF_SEL:0] C_FULL = (RRF_SEL+1)'(RRF_NUM);

  logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
  logic [RRF_SEL-1:0] comptr_q, comptr_d;
  logic [RRF_SEL:0]   freenum_q, freenum_d;

  logic [1:0] w_reqnum;
  logic [1:0] w_allocnum;
  logic       w_stall;
  logic       w_grant;

  // Stall looks only at the registered free count; same-cycle commits do not help.
  always_comb begin
    w_reqnum   = {1'b0, bus.req1_i} + {1'b0, bus.req2_i};
    w_stall    = {{(RRF_SEL-1){1'b0}}, w_reqnum} > freenum_q;
    w_grant    = ~w_stall & ~bus.stall_dp_i & ~bus.flush_i & ~reset_i;
    w_allocnum = w_grant ? w_reqnum : 2'd0;
  end

  always_comb begin
    comptr_d = comptr_q + {{(RRF_SEL-2){1'b0}}, bus.com_num_i};
    if (bus.flush_i) begin
      rrfptr_d  = comptr_d;
      freenum_d = C_FULL;
    end else begin
      rrfptr_d  = rrfptr_q + {{(RRF_SEL-2){1'b0}}, w_allocnum};
      freenum_d = freenum_q
                + {{(RRF_SEL-1){1'b0}}, bus.com_num_i}
                - {{(RRF_SEL-1){1'b0}}, w_allocnum};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rrfptr_q  <= '0;
      comptr_q  <= '0;
      freenum_q <= C_FULL;
    end else begin
      rrfptr_q  <= rrfptr_d;
      comptr_q  <= comptr_d;
      freenum_q <= freenum_d;
    end
  end

  // A lone slot-2 request takes the head tag.
  always_comb begin
    bus.alloc_en1_o   = bus.req1_i & w_grant;
    bus.alloc_en2_o   = bus.req2_i & w_grant;
    bus.alloc_tag1_o  = rrfptr_q;
    bus.alloc_tag2_o  = rrfptr_q + {{(RRF_SEL-1){1'b0}}, bus.req1_i};
    bus.alloc_stall_o = w_stall;
    bus.freenum_o     = freenum_q;
    bus.rrfptr_o      = rrfptr_q;
    bus.comptr_o      = comptr_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_rrf_alloc_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_rrf_alloc_ctrl : directed bench for the RRF allocation controller |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rrf_alloc_ctrl;

  logic clk;
  logic reset_i;
  int   vectors;
  int   miscompares;

  rrf_alloc_ctrl_if #(.RRF_SEL(6)) bus ();

  rrf_alloc_ctrl #(.RRF_NUM(64), .RRF_SEL(6)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r1, input logic r2, input logic sdp,
                       input logic [1:0] cn, input logic fl);
    bus.req1_i     = r1;
    bus.req2_i     = r2;
    bus.stall_dp_i = sdp;
    bus.com_num_i  = cn;
    bus.flush_i    = fl;
    #1;
  endtask

  // Commit count must be 0..2 and never exceed the outstanding allocations.
  always @(posedge clk) begin
    if (!reset_i) begin
      assert (bus.com_num_i != 2'd3 && int'(bus.com_num_i) <= 64 - int'(bus.freenum_o)) else begin
        miscompares++;
        $error("FAIL illegal_com: observed %0d expected <= %0d", bus.com_num_i, 64 - int'(bus.freenum_o));
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_i     = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    cyc();
    chk("rst_freenum", bus.freenum_o, 64);
    chk("rst_rrfptr",  bus.rrfptr_o, 0);
    chk("rst_comptr",  bus.comptr_o, 0);
    chk("rst_en1",     bus.alloc_en1_o, 0);
    chk("rst_en2",     bus.alloc_en2_o, 0);
    chk("rst_stall",   bus.alloc_stall_o, 0);
    chk("rst_tag1",    bus.alloc_tag1_o, 0);
    reset_i = 1'b0;

    // Drain all 64 tags two at a time.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      chk("burst_en1",  bus.alloc_en1_o, 1);
      chk("burst_en2",  bus.alloc_en2_o, 1);
      chk("burst_tag1", bus.alloc_tag1_o, 2*i);
      chk("burst_tag2", bus.alloc_tag2_o, 2*i+1);
      cyc();
    end
    chk("empty_freenum", bus.freenum_o, 0);
    chk("empty_rrfptr",  bus.rrfptr_o, 0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("empty_stall", bus.alloc_stall_o, 1);
    chk("empty_en1",   bus.alloc_en1_o, 0);
    cyc();

    // Free a single tag, then ask for two while committing two.
    drive(1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    cyc();
    chk("one_freenum", bus.freenum_o, 1);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
    chk("partial_stall", bus.alloc_stall_o, 1);
    chk("partial_en1",   bus.alloc_en1_o, 0);
    chk("partial_en2",   bus.alloc_en2_o, 0);
    cyc();
    chk("partial_freenum", bus.freenum_o, 3);
    chk("partial_comptr",  bus.comptr_o, 3);
    chk("partial_rrfptr",  bus.rrfptr_o, 0);

    // Flush with no commit: rrfptr snaps to comptr=3.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("flush0_en1", bus.alloc_en1_o, 0);
    cyc();
    chk("flush0_rrfptr",  bus.rrfptr_o, 3);
    chk("flush0_freenum", bus.freenum_o, 64);

    // Move rrfptr to 10, then a lone slot-2 request.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      cyc();
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc();
    chk("pre_lone_rrfptr", bus.rrfptr_o, 10);
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("lone_tag2", bus.alloc_tag2_o, 10);
    chk("lone_en2",  bus.alloc_en2_o, 1);
    chk("lone_en1",  bus.alloc_en1_o, 0);
    cyc();
    chk("lone_rrfptr",  bus.rrfptr_o, 11);
    chk("lone_freenum", bus.freenum_o, 56);

    // Advance to rrfptr=63, comptr=19, freenum=20.
    for (int i = 0; i < 26; i++) begin
      drive(1'b1, 1'b1, 1'b0, (i < 8) ? 2'd2 : 2'd0, 1'b0);
      cyc();
    end
    chk("prewrap_rrfptr",  bus.rrfptr_o, 63);
    chk("prewrap_comptr",  bus.comptr_o, 19);
    chk("prewrap_freenum", bus.freenum_o, 20);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    chk("wrap_tag1", bus.alloc_tag1_o, 63);
    chk("wrap_tag2", bus.alloc_tag2_o, 0);
    chk("wrap_en1",  bus.alloc_en1_o, 1);
    chk("wrap_en2",  bus.alloc_en2_o, 1);
    cyc();
    chk("wrap_rrfptr",  bus.rrfptr_o, 1);
    chk("wrap_freenum", bus.freenum_o, 19);
    chk("wrap_comptr",  bus.comptr_o, 20);

    // Re-align to comptr=5, rrfptr=30.
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    cyc();
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    cyc();
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      cyc();
    end
    drive(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    cyc();
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      cyc();
    end
    chk("preflush_comptr",  bus.comptr_o, 5);
    chk("preflush_rrfptr",  bus.rrfptr_o, 30);
    chk("preflush_freenum", bus.freenum_o, 39);
    drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
    chk("flush_en1", bus.alloc_en1_o, 0);
    cyc();
    chk("flush_comptr",  bus.comptr_o, 7);
    chk("flush_rrfptr",  bus.rrfptr_o, 7);
    chk("flush_freenum", bus.freenum_o, 64);

    // Bring freenum to 40, then a downstream stall.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      cyc();
    end
    chk("pre_sdp_freenum", bus.freenum_o, 40);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    chk("sdp_stall", bus.alloc_stall_o, 0);
    chk("sdp_en1",   bus.alloc_en1_o, 0);
    chk("sdp_en2",   bus.alloc_en2_o, 0);
    cyc();
    chk("sdp_rrfptr",  bus.rrfptr_o, 31);
    chk("sdp_freenum", bus.freenum_o, 40);

    // Asynchronous reset in the middle of a granting cycle.
    drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("pre_arst_en1", bus.alloc_en1_o, 1);
    reset_i = 1'b1;
    #1;
    chk("arst_freenum", bus.freenum_o, 64);
    chk("arst_rrfptr",  bus.rrfptr_o, 0);
    chk("arst_en1",     bus.alloc_en1_o, 0);
    chk("arst_en2",     bus.alloc_en2_o, 0);
    cyc();
    reset_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
